// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port of the fetch stage: the fetch sequencer drives
// req/addr, the memory answers with ack/rdata in the cycle the word is valid.
interface fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs the req/ack handshake to
// instruction memory, presents words to D through a one-entry skid buffer and
// applies NPC redirects with delay-slot semantics (the word already held or in
// flight when a branch is captured is delivered unmodified).
//
//   state  | meaning
//   IDLE   | single quiet cycle after reset, no request
//   REQ    | request outstanding at fetch_pc, waiting for ack
//   HOLD   | skid full, request paused until D drains a word
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_3000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic [31:0]       npc,
    fetch_ctrl_if.master      imem,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(IMEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        redir_valid_q, redir_valid_d;
    logic [31:0] redir_target_q, redir_target_d;
    logic [7:0]  timer_q, timer_d;
    logic        fetch_err_q, fetch_err_d;

    logic        ack_take;
    logic        consume;
    logic        to_slot;
    logic        branch_ok;
    logic [31:0] npc_aligned;

    // Handshake qualifiers shared by the next-state and datapath logic.
    always_comb begin
        ack_take    = (state_q == S_REQ) && imem.ack;
        consume     = if_valid_q && !stall;
        // A word can go straight to D if the slot is empty, or is being
        // consumed this edge and no older word waits in the skid.
        to_slot     = !if_valid_q || (!stall && !skid_valid_q);
        branch_ok   = branch && !stall;
        npc_aligned = {npc[31:2], 2'b00};
    end

    // All state flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            fetch_pc_q     <= RESET_PC;
            if_valid_q     <= 1'b0;
            if_instr_q     <= 32'h0;
            if_pc_q        <= RESET_PC;
            skid_valid_q   <= 1'b0;
            skid_instr_q   <= 32'h0;
            skid_pc_q      <= 32'h0;
            redir_valid_q  <= 1'b0;
            redir_target_q <= 32'h0;
            timer_q        <= 8'h0;
            fetch_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            if_valid_q     <= if_valid_d;
            if_instr_q     <= if_instr_d;
            if_pc_q        <= if_pc_d;
            skid_valid_q   <= skid_valid_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
            redir_valid_q  <= redir_valid_d;
            redir_target_q <= redir_target_d;
            timer_q        <= timer_d;
            fetch_err_q    <= fetch_err_d;
        end
    end

    // Next-state: pause requesting once the skid has to absorb a word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (ack_take && !to_slot) state_d = S_HOLD;
            S_HOLD: if (consume) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: D slot / skid refill, fetch PC advance, redirect and timeout.
    always_comb begin
        if_valid_d     = if_valid_q;
        if_instr_d     = if_instr_q;
        if_pc_d        = if_pc_q;
        skid_valid_d   = skid_valid_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;
        fetch_pc_d     = fetch_pc_q;
        redir_valid_d  = redir_valid_q;
        redir_target_d = redir_target_q;
        timer_d        = timer_q;
        fetch_err_d    = fetch_err_q;

        // Skid is older than any ack, so it refills the slot first.
        if (consume) begin
            if (skid_valid_q) begin
                if_instr_d   = skid_instr_q;
                if_pc_d      = skid_pc_q;
                skid_valid_d = 1'b0;
            end else if (ack_take) begin
                if_instr_d = imem.rdata;
                if_pc_d    = fetch_pc_q;
            end else begin
                if_valid_d = 1'b0;
            end
        end else if (ack_take && !if_valid_q) begin
            if_valid_d = 1'b1;
            if_instr_d = imem.rdata;
            if_pc_d    = fetch_pc_q;
        end

        if (ack_take && !to_slot) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem.rdata;
            skid_pc_d    = fetch_pc_q;
        end

        // A pending redirect wins over a branch on the same edge.
        if (ack_take) begin
            if (redir_valid_q) begin
                fetch_pc_d    = redir_target_q;
                redir_valid_d = 1'b0;
            end else if (branch_ok) begin
                fetch_pc_d = npc_aligned;
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end else if (branch_ok) begin
            redir_valid_d  = 1'b1;
            redir_target_d = npc_aligned;
        end

        // Timer saturates at the limit; the request itself stays up.
        if (ack_take) begin
            timer_d = 8'h0;
        end else if (state_q == S_REQ) begin
            if (timer_q != TIMEOUT_CNT) timer_d = timer_q + 8'd1;
            if (timer_d == TIMEOUT_CNT) fetch_err_d = 1'b1;
        end
    end

    // Outputs straight from state and registers.
    always_comb begin
        imem.req  = (state_q == S_REQ);
        imem.addr = fetch_pc_q;
        if_valid  = if_valid_q;
        if_instr  = if_instr_q;
        if_pc     = if_pc_q;
        fetch_err = fetch_err_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by a random phase, all
// checked against a queue-based model of the words held for D and the
// expected fetch address stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch;
    logic [31:0] npc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_err;

    fetch_ctrl_if imem_bus ();

    fetch_ctrl #(.RESET_PC(RST_PC), .IMEM_TIMEOUT(255)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .branch    (branch),
        .npc       (npc),
        .imem      (imem_bus),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc     (if_pc),
        .fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory responder settings: 0 = latency-based, 1 = never acks, 2 = always acks.
    int mem_mode  = 0;
    int lat_fixed = 0;
    bit lat_rand  = 1'b0;
    int lat_cur   = 0;
    int wait_cnt  = 0;

    // Reference model: words waiting for D in order, plus the fetch stream.
    logic [31:0] m_qpc[$];
    logic [31:0] m_qin[$];
    logic [31:0] m_pc;
    bit          m_known = 1'b0;
    bit          m_idle;
    bit          m_rv;
    logic [31:0] m_rt;
    int          m_timer;
    bit          m_err;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit m_req();
        return !m_idle && (m_qpc.size() < 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_mem(input int mode, input int lat, input bit rnd);
        mem_mode  = mode;
        lat_fixed = lat;
        lat_rand  = rnd;
        lat_cur   = lat;
        wait_cnt  = 0;
    endtask

    task automatic verify();
        if (!m_known) return;
        check("imem_req", 32'(imem_bus.req), 32'(m_req()));
        if (m_req() || m_idle) check("imem_addr", imem_bus.addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(m_qpc.size() > 0));
        if (m_qpc.size() > 0) begin
            check("if_pc", if_pc, m_qpc[0]);
            check("if_instr", if_instr, m_qin[0]);
        end
        check("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    task automatic drive_mem();
        imem_bus.rdata = instr_of(imem_bus.addr);
        case (mem_mode)
            1: imem_bus.ack = 1'b0;
            2: imem_bus.ack = 1'b1;
            default: begin
                if (imem_bus.req === 1'b1) begin
                    if (wait_cnt >= lat_cur) begin
                        imem_bus.ack = 1'b1;
                        wait_cnt = 0;
                        lat_cur = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
                    end else begin
                        imem_bus.ack = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    imem_bus.ack = 1'b0;
                    wait_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic model_edge();
        bit req;
        bit ack;
        bit brk;
        if (reset === 1'b0) begin
            m_qpc.delete();
            m_qin.delete();
            m_pc    = RST_PC;
            m_idle  = 1'b1;
            m_rv    = 1'b0;
            m_rt    = 32'h0;
            m_timer = 0;
            m_err   = 1'b0;
            m_known = 1'b1;
            return;
        end
        if (!m_known) return;
        req = m_req();
        ack = req && (imem_bus.ack === 1'b1);
        brk = (branch === 1'b1) && (stall === 1'b0);
        if (m_qpc.size() > 0 && stall === 1'b0) begin
            m_qpc.delete(0);
            m_qin.delete(0);
        end
        if (ack) begin
            m_qpc.push_back(m_pc);
            m_qin.push_back(instr_of(m_pc));
            if (m_rv) begin
                m_pc = m_rt;
                m_rv = 1'b0;
            end else if (brk) begin
                m_pc = npc & 32'hFFFF_FFFC;
            end else begin
                m_pc = m_pc + 32'd4;
            end
            m_timer = 0;
        end else begin
            if (brk) begin
                m_rv = 1'b1;
                m_rt = npc & 32'hFFFF_FFFC;
            end
            if (req) begin
                if (m_timer < 255) m_timer++;
                if (m_timer == 255) m_err = 1'b1;
            end
        end
        m_idle = 1'b0;
    endtask

    // One clock: check at negedge, drive inputs, let the edge happen, update model.
    task automatic step(input bit rst_n, input bit st, input bit br, input logic [31:0] np);
        @(negedge clk);
        verify();
        reset  = rst_n;
        stall  = st;
        branch = br;
        npc    = np;
        drive_mem();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_step();
        step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_until_pc(input logic [31:0] pc, input string tag);
        int n = 0;
        while (!(if_valid === 1'b1 && if_pc === pc) && n < 50) begin
            idle_step();
            n++;
        end
        check(tag, 32'(if_valid === 1'b1 && if_pc === pc), 32'h1);
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        branch = 1'b0;
        npc = 32'h0;
        imem_bus.ack = 1'b0;
        imem_bus.rdata = 32'h0;

        // Reset values and zero-wait streaming.
        set_mem(0, 0, 1'b0);
        do_reset();
        check("rst_req", 32'(imem_bus.req), 32'h0);
        check("rst_addr", imem_bus.addr, RST_PC);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, RST_PC);
        check("rst_err", 32'(fetch_err), 32'h0);
        idle_step();
        for (int k = 0; k < 6; k++) begin
            check("zw_addr", imem_bus.addr, RST_PC + 32'(4 * k));
            if (k > 0) begin
                check("zw_if_valid", 32'(if_valid), 32'h1);
                check("zw_if_pc", if_pc, RST_PC + 32'(4 * (k - 1)));
            end
            idle_step();
        end

        // Stall with a two-wait memory: one word lands in the skid, then fetch pauses.
        set_mem(0, 2, 1'b0);
        do_reset();
        idle_step();
        run_until_pc(32'h0000_3004, "stall_reach_3004");
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            check("stall_if_pc", if_pc, 32'h0000_3004);
        end
        check("stall_req_low", 32'(imem_bus.req), 32'h0);
        idle_step();
        check("skid_deliver", if_pc, 32'h0000_3008);
        check("skid_resume_req", 32'(imem_bus.req), 32'h1);
        check("skid_resume_addr", imem_bus.addr, 32'h0000_300C);

        // Branch while 3008 is in flight: 3008 is the delay slot.
        do_reset();
        idle_step();
        run_until_pc(32'h0000_3004, "br_reach_3004");
        step(1'b1, 1'b0, 1'b1, 32'h0000_3100);
        run_until_pc(32'h0000_3008, "br_delay_slot");
        check("br_target_addr", imem_bus.addr, 32'h0000_3100);
        run_until_pc(32'h0000_3100, "br_target_delivered");
        check("br_after_target", imem_bus.addr, 32'h0000_3104);

        // Branch on the same edge as an ack, then PC wrap with alignment.
        set_mem(0, 0, 1'b0);
        do_reset();
        idle_step();
        idle_step();
        idle_step();
        step(1'b1, 1'b0, 1'b1, 32'h0000_3200);
        check("br_ack_addr", imem_bus.addr, 32'h0000_3200);
        idle_step();
        check("br_ack_no_redir", imem_bus.addr, 32'h0000_3204);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check("wrap_top", imem_bus.addr, 32'hFFFF_FFFC);
        idle_step();
        check("wrap_zero", imem_bus.addr, 32'h0000_0000);
        idle_step();
        check("wrap_four", imem_bus.addr, 32'h0000_0004);

        // Dead memory: timeout after 255 request cycles, then reset mid-request.
        set_mem(1, 0, 1'b0);
        do_reset();
        idle_step();
        for (int k = 0; k < 254; k++) idle_step();
        check("to_err_254", 32'(fetch_err), 32'h0);
        idle_step();
        check("to_err_255", 32'(fetch_err), 32'h1);
        check("to_req_held", 32'(imem_bus.req), 32'h1);
        set_mem(2, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("mid_rst_req", 32'(imem_bus.req), 32'h0);
        check("mid_rst_err", 32'(fetch_err), 32'h0);
        check("mid_rst_addr", imem_bus.addr, RST_PC);
        idle_step();
        check("late_ack_addr", imem_bus.addr, RST_PC);
        check("late_ack_valid", 32'(if_valid), 32'h0);

        // Random traffic against the model.
        set_mem(0, 1, 1'b1);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          s;
            bit          b;
            logic [31:0] t;
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 10);
            t = $urandom;
            if ($urandom_range(0, 9) != 0) t = t & 32'h0000_FFFF;
            step(r, s, b, t);
        end
        idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer: owns the architectural fetch PC and issues requests to a multi-cycle instruction memory using a req/ack handshake.
- Presents fetched instructions to the D stage. A one-entry skid buffer absorbs D-stage stalls.
- Applies redirects from the next-PC unit (branch/jump target) with MIPS delay-slot semantics.
- Sits between the NPC logic, the hazard unit and the instruction memory port.

Parameters:
- RESET_PC, 32'h00003000, first fetch address after reset.
- IMEM_TIMEOUT, 255, maximum ack wait in cycles before the error flag is set; 8-bit counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- stall  in  1  hazard unit: D stage cannot accept; hold if_* outputs.
- branch  in  1  NPC: redirect request from instruction currently in D.
- npc  in  32  NPC: redirect target; valid when branch=1.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory: imem_rdata valid this cycle; request complete.
- imem_rdata  in  32  fetched instruction word.
- if_valid  out  1  if_instr/if_pc hold a valid instruction for D.
- if_instr  out  32  instruction to D stage.
- if_pc  out  32  address of if_instr; feeds NPC pc input.
- fetch_err  out  1  sticky: ack timeout occurred.

Behaviour:
- Reset (reset=0 at edge):
  - fetch_pc=RESET_PC; state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_instr=0, if_pc=RESET_PC.
  - Skid buffer empty; redir_valid=0; timer=0; fetch_err=0.
  - Reset asserted mid-request drops the request; a late ack after reset is ignored while in IDLE.
- States:
  - IDLE: imem_req=0. Always moves to REQ next cycle. Exactly one idle cycle after reset.
  - REQ: imem_req=1, imem_addr=fetch_pc. Address and req stay stable until ack is sampled high. Ack in the same cycle req rises is legal (zero-wait memory gives one instruction per cycle).
  - HOLD: skid full; imem_req=0. Returns to REQ on the edge where the skid drains.
- Ack handling (edge with state=REQ and imem_ack=1):
  - Destination:
    - if if_valid=0, or stall=0 (slot consumed this edge) with skid empty: word loads into if_instr/if_pc/if_valid=1.
    - otherwise: word loads into skid and state goes to HOLD.
  - fetch_pc update (priority order):
    1. redir_valid=1 → redir_target, clear redir_valid.
    2. branch=1 and stall=0 at this edge → npc.
    3. otherwise fetch_pc+4, 32-bit wrap (FFFFFFFC → 00000000).
- Redirect capture:
  - On an edge with branch=1 and stall=0 and no ack consumed: set redir_valid=1, redir_target=npc.
  - Branch while stall=1 is ignored; NPC re-presents it.
  - A second branch while redir_valid=1 overwrites the target; last one wins.
- Delay slot:
  - The instruction already in if_*, skid, or in flight when the branch is captured is the delay slot and is delivered unmodified.
  - No squash occurs.
- Consumption:
  - Edge with if_valid=1 and stall=0: slot refills from skid if full (skid empties), else from a simultaneous ack, else if_valid=0.
  - Skid has priority over ack, preserving order.
  - With skid full, no new request is issued, so skid and ack can never collide.
- Stall:
  - if_* are frozen while stall=1.
  - Only one further fetch may complete during a stall (into skid); fetching then pauses.
- Timeout:
  - timer increments each REQ cycle without ack and clears on ack.
  - At IMEM_TIMEOUT, fetch_err=1 (sticky until reset); the request stays asserted.
- Alignment: npc[1:0] are forced to 00 on capture.

Test Plan:
1. Zero-wait memory (ack=req), no stalls, release reset → imem_addr 3000,3004,3008… on consecutive cycles from cycle 2. if_pc trails by one cycle; if_valid=1 continuously.
2. Two-wait memory, stall=1 for 5 cycles while if_pc=3004 → if_* frozen at 3004; one ack lands in skid (3008); req stays low. After release, 3008 is delivered the next cycle, then the 300C fetch resumes.
3. branch=1, npc=3100 with if_pc=3004 and fetch 3008 in flight → 3008 delivered as delay slot; next imem_addr=3100, then 3104.
4. branch and ack on the same edge, npc=3200 → fetch_pc=3200 directly; redir_valid stays 0.
5. Force fetch_pc=FFFFFFFC via branch → following address is 00000000.
6. Memory never acks → fetch_err=1 after 255 REQ cycles. reset=0 mid-request → req drops, state=IDLE, fetch_err clears, restart at 3000.
